// File: rtl/mult_pin_host.sv
// mult_pin_host: drives operand pairs onto the multiplier tile pins, captures and self-checks the product
module mult_pin_host #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    output logic [7:0]       pin_ui_in,
    output logic [7:0]       pin_uio_in,
    input  logic [7:0]       pin_uo_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_a,
    output logic [3:0]       res_b,
    output logic [7:0]       res_product,
    output logic             res_mismatch,
    output logic [ERR_W-1:0] err_count,
    input  logic             clr_err,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;
    state_t     state;
    logic [3:0] cnt;
    logic [7:0] exp_p;
    logic       cap;
    logic       miss;
    // pin_ui_in doubles as the operand store for the operation in flight
    assign exp_p      = {4'b0, pin_ui_in[3:0]} * {4'b0, pin_ui_in[7:4]};
    assign cap        = state == DRIVE && cnt == 4'd0;
    assign miss       = pin_uo_out != exp_p;
    assign in_ready   = ena && state == IDLE;
    assign busy       = state != IDLE;
    assign pin_uio_in = 8'h00;
    // Operation sequencer: accept, wait for the tile to settle, capture, hand off the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            pin_ui_in    <= 8'h00;
            res_valid    <= 1'b0;
            res_a        <= 4'd0;
            res_b        <= 4'd0;
            res_product  <= 8'h00;
            res_mismatch <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    pin_ui_in <= {in_b, in_a};
                    cnt       <= 4'(SETTLE_CYCLES - 1);
                    state     <= DRIVE;
                end
                DRIVE: if (cap) begin
                    res_product  <= pin_uo_out;
                    res_a        <= pin_ui_in[3:0];
                    res_b        <= pin_ui_in[7:4];
                    res_mismatch <= miss;
                    res_valid    <= 1'b1;
                    state        <= HOLD;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                HOLD: if (res_ready) begin
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Saturating mismatch counter; a clear on the capture edge takes priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_count <= '0;
        else if (clr_err)
            err_count <= '0;
        else if (cap && miss && err_count != '1)
            err_count <= err_count + ERR_W'(1);
    end
endmodule

// File: tb/tb_mult_pin_host.sv
// tb_mult_pin_host: timestamp-based reference model plus directed vectors for mult_pin_host
module tb_mult_pin_host;
    localparam int SETTLE = 2;
    logic       clk = 0, rst_n = 0, ena = 0, in_valid = 0, res_ready = 0, clr_err = 0;
    logic [3:0] in_a = 0, in_b = 0;
    logic [7:0] pin_ui_in, pin_uio_in, pin_uo_out;
    logic       in_ready, res_valid, res_mismatch, busy;
    logic [3:0] res_a, res_b;
    logic [7:0] res_product, err_count;
    logic       faulty = 0;
    int         n_cmp = 0, n_bad = 0;
    int         cyc = 0;

    mult_pin_host #(.SETTLE_CYCLES(SETTLE), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .pin_ui_in(pin_ui_in), .pin_uio_in(pin_uio_in),
        .pin_uo_out(pin_uo_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_a(res_a), .res_b(res_b), .res_product(res_product), .res_mismatch(res_mismatch),
        .err_count(err_count), .clr_err(clr_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] tile(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        p = 8'(int'(a) * int'(b));
        return faulty ? p ^ 8'h01 : p;
    endfunction

    assign pin_uo_out = tile(pin_ui_in[3:0], pin_ui_in[7:4]);

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: one op in flight, result due SETTLE edges after the accept edge
    logic       m_busy, m_valid, m_mis;
    logic [3:0] m_a, m_b;
    logic [7:0] m_p, m_pin, m_err;
    int         m_due;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_valid <= 0; m_mis <= 0; m_a <= 0; m_b <= 0;
            m_p <= 0; m_pin <= 0; m_err <= 0; m_due <= 0;
        end else begin
            if (clr_err) m_err <= 0;
            if (!m_busy) begin
                if (ena && in_valid) begin
                    m_busy <= 1; m_a <= in_a; m_b <= in_b;
                    m_pin <= {in_b, in_a}; m_due <= cyc + SETTLE;
                end
            end else if (!m_valid) begin
                if (cyc == m_due) begin
                    m_valid <= 1;
                    m_p     <= tile(m_a, m_b);
                    m_mis   <= tile(m_a, m_b) != 8'(int'(m_a) * int'(m_b));
                    if (!clr_err && tile(m_a, m_b) != 8'(int'(m_a) * int'(m_b)) && m_err != 8'd255)
                        m_err <= m_err + 8'd1;
                end
            end else if (res_ready) begin
                m_valid <= 0; m_busy <= 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("res_valid", res_valid, m_valid);
        chk("busy", busy, m_busy);
        chk("in_ready", in_ready, ena && !m_busy);
        chk("pin_ui_in", pin_ui_in, m_pin);
        chk("pin_uio_in", pin_uio_in, 0);
        chk("err_count", err_count, m_err);
        if (m_valid) begin
            chk("res_a", res_a, m_a);
            chk("res_b", res_b, m_b);
            chk("res_product", res_product, m_p);
            chk("res_mismatch", res_mismatch, m_mis);
        end
    end

    // One operation: accept, wait for result (optionally clearing on capture edge), hold, handshake
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input int hold, input logic clr,
                         output logic [7:0] p, output logic mis, output int lat);
        int w = 0;
        while (!in_ready && w < 20) begin @(posedge clk); #2; w++; end
        chk("in_ready_wait", int'(in_ready), 1);
        in_a = a; in_b = b; in_valid = 1;
        @(posedge clk); #2 in_valid = 0;
        lat = 0;
        while (!res_valid && lat < 20) begin
            if (lat == SETTLE - 1) clr_err = clr;
            @(posedge clk); #2;
            clr_err = 0;
            lat++;
        end
        chk("res_valid_timeout", int'(res_valid), 1);
        p = res_product; mis = res_mismatch;
        repeat (hold) begin
            @(posedge clk); #2;
            chk("hold_valid", res_valid, 1);
            chk("hold_product", res_product, p);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_busy", busy, 1);
        end
        res_ready = 1;
        @(posedge clk); #2 res_ready = 0;
    endtask

    initial begin
        logic [7:0] p;
        logic       mis;
        int         lat;
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_pin_ui_in", pin_ui_in, 0);
        chk("rst_err", err_count, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1; ena = 1;
        // 1: 3*5 on a correct tile
        do_op(4'd3, 4'd5, 0, 0, p, mis, lat);
        chk("t1_latency", lat, 2);
        chk("t1_product", p, 15);
        chk("t1_mismatch", mis, 0);
        chk("t1_pin_kept", pin_ui_in, 8'h53);
        // 2: corners
        do_op(4'd15, 4'd15, 0, 0, p, mis, lat);
        chk("t2_product_max", p, 225);
        chk("t2_mismatch_max", mis, 0);
        do_op(4'd0, 4'd9, 0, 0, p, mis, lat);
        chk("t2_product_zero", p, 0);
        // 3: faulty tile
        faulty = 1;
        chk("t3_err_before", err_count, 0);
        do_op(4'd2, 4'd3, 0, 0, p, mis, lat);
        chk("t3_product", p, 7);
        chk("t3_mismatch", mis, 1);
        chk("t3_err_after", err_count, 1);
        faulty = 0;
        // 4: consumer back-pressure
        do_op(4'd7, 4'd6, 10, 0, p, mis, lat);
        chk("t4_product", p, 42);
        chk("t4_in_ready_after", in_ready, 1);
        // 5: reset during DRIVE
        in_a = 4'd4; in_b = 4'd4; in_valid = 1;
        @(posedge clk); #2 in_valid = 0;
        chk("t5_busy_drive", busy, 1);
        ena = 0;
        #1 rst_n = 0;
        #1;
        chk("t5_rst_valid", res_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_pin", pin_ui_in, 0);
        chk("t5_rst_err", err_count, 0);
        chk("t5_rst_product", res_product, 0);
        @(posedge clk); #2 rst_n = 1;
        repeat (10) begin
            @(posedge clk); #2;
            chk("t5_no_valid", res_valid, 0);
        end
        ena = 1;
        // 6: saturation then clear on the capture edge
        faulty = 1;
        for (int i = 0; i < 299; i++) do_op(4'(i), 4'(i >> 4), 0, 0, p, mis, lat);
        chk("t6_err_peak", err_count, 255);
        do_op(4'd9, 4'd9, 0, 1, p, mis, lat);
        chk("t6_err_cleared", err_count, 0);
        chk("t6_mismatch", mis, 1);
        faulty = 0;
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
